pe_array_ctrl: RTL and testbench

Sequencer for the 2-D PE array built from `mac_tile` instances. It accepts a job, then issues the 3-bit tile instruction stream into the west edge of row 0. The stream is delayed by one cycle per row to form the diagonal wavefront. The block throttles on L0-input-FIFO emptiness and supports weight-stationary (WS) and, optionally, output-stationary (OS) dataflows.

---
 rtl/pe_array_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for the 2-D mac_tile PE array.
//
// Accepts a job (mode, vector count), then emits the 3-bit tile instruction
// stream into row 0. Each further row sees the same stream one cycle later
// through a flop chain, which forms the diagonal wavefront across the array.
// Load and execute phases throttle on L0 FIFO emptiness.
//
// Configuration macro: PE_ARRAY_CTRL_OS_EN
//   defined   -> output-stationary jobs (mode=1) are supported
//   undefined -> mode is ignored, every job runs weight-stationary
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   job request, taken only while ready=1
//   mode      in   0=WS, 1=OS (latched on accept)
//   num_vec   in   execute vector count (latched on accept)
//   l0_empty  in   L0 FIFO empty, stalls load/execute phases
//   l0_rd     out  L0 read strobe (combinational)
//   inst_row  out  per-row instruction, row r at [3r+2:3r]
//   ready     out  high while idle
//   busy      out  inverse of ready
//   done      out  one-cycle pulse at job completion
module pe_array_ctrl #(
  parameter int col    = 8,
  parameter int row    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [len_bw-1:0] num_vec,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [3*row-1:0]  inst_row,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] W_IDLE  = 3'b000;
  localparam logic [2:0] W_LOAD  = 3'b001;
  localparam logic [2:0] W_EXEC  = 3'b010;
`ifdef PE_ARRAY_CTRL_OS_EN
  localparam logic [2:0] O_SHIFT = 3'b101;
  localparam logic [2:0] O_EXEC  = 3'b110;
  localparam logic [2:0] O_RESET = 3'b111;
  localparam logic [len_bw-1:0] SHIFT_LAST = len_bw'(row);
`endif

  // Phase counters count 0..N-1, so the terminal values are N-1.
  localparam logic [len_bw-1:0] LOAD_LAST  = len_bw'(col - 1);
  localparam logic [len_bw-1:0] DRAIN_LAST = len_bw'(row + col - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WEXEC,
    S_DRAIN,
    S_DONE
`ifdef PE_ARRAY_CTRL_OS_EN
    ,
    S_CLR,
    S_OEXEC,
    S_OSHIFT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [len_bw-1:0] cnt_q, cnt_d;
  logic [len_bw-1:0] nv_q, nv_d;
  logic              os_q, os_d;
  logic [3*row-1:0]  chain_q, chain_d;
  logic [2:0]        code;
  logic [2:0]        idle_code;
  logic              stallable;
  logic              issue;

`ifdef PE_ARRAY_CTRL_OS_EN
  assign stallable = (state_q == S_WLOAD) || (state_q == S_WEXEC) || (state_q == S_OEXEC);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign stallable   = (state_q == S_WLOAD) || (state_q == S_WEXEC);
`endif

  assign issue     = stallable && !l0_empty;
  assign l0_rd     = issue;
  assign idle_code = {os_q, 2'b00};
  assign ready     = (state_q == S_IDLE);
  assign busy      = !ready;
  assign done      = (state_q == S_DONE);
  assign inst_row  = chain_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    os_d    = os_q;
    code    = idle_code;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d = num_vec;
`ifdef PE_ARRAY_CTRL_OS_EN
          os_d    = mode;
          state_d = mode ? S_CLR : S_WLOAD;
`else
          os_d    = 1'b0;
          state_d = S_WLOAD;
`endif
        end
      end
      S_WLOAD: begin
        if (issue) begin
          code  = W_LOAD;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LOAD_LAST)
            state_d = (nv_q == '0) ? S_DRAIN : S_WEXEC;
        end
      end
      S_WEXEC: begin
        if (issue) begin
          code  = W_EXEC;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == nv_q - 1'b1)
            state_d = S_DRAIN;
        end
      end
`ifdef PE_ARRAY_CTRL_OS_EN
      S_CLR: begin
        code    = O_RESET;
        state_d = (nv_q == '0) ? S_OSHIFT : S_OEXEC;
      end
      S_OEXEC: begin
        if (issue) begin
          code  = O_EXEC;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == nv_q - 1'b1)
            state_d = S_OSHIFT;
        end
      end
      S_OSHIFT: begin
        // row+1 shifts: one extra for the tile's shift-priming cycle.
        code  = O_SHIFT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHIFT_LAST)
          state_d = S_DRAIN;
      end
`endif
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Every phase starts counting from zero.
    if (state_d != state_q)
      cnt_d = '0;
  end

  // Row 0 takes the freshly decoded code; row r takes row r-1's previous value.
  always_comb begin
    chain_d      = chain_q;
    chain_d[2:0] = code;
    for (int r = 1; r < row; r++)
      chain_d[3*r +: 3] = chain_q[3*(r-1) +: 3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nv_q    <= '0;
      os_q    <= 1'b0;
      chain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
      os_q    <= os_d;
      chain_q <= chain_d;
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
module tb_pe_array_ctrl;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int LBW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mode;
  logic [LBW-1:0]   num_vec;
  logic             l0_empty;
  logic             l0_rd;
  logic [3*ROW-1:0] inst_row;
  logic             ready;
  logic             busy;
  logic             done;

  int vectors = 0;
  int errors  = 0;
  int hist[0:4095];

  pe_array_ctrl #(.col(COL), .row(ROW), .len_bw(LBW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vec(num_vec),
    .l0_empty(l0_empty), .l0_rd(l0_rd), .inst_row(inst_row),
    .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; num_vec = '0; l0_empty = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (inst_row !== '0) begin errors++; $display("FAIL reset_inst_row got %h want 0", inst_row); end
    vectors++; if (l0_rd !== 1'b0) begin errors++; $display("FAIL reset_l0_rd got %b want 0", l0_rd); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Runs one job against a phase-list model. stall_pct sets the chance that
  // l0_empty is high in any cycle; busy_starts sprinkles ignored start pulses.
  task automatic run_job(input bit m, input int nv, input int stall_pct,
                         input bit busy_starts, input string name);
    bit   os;
    int   pc[4], pn[4];
    bit   ps[4];
    int   nph, ph, rem, idle, j, done_j, code, dones;
    bit   emp, exp_rd, exp_done, exp_ready, in_job;
`ifdef PE_ARRAY_CTRL_OS_EN
    os = m;
`else
    os = 1'b0;
`endif
    idle = os ? 4 : 0;
    if (!os) begin
      pc[0] = 1; pn[0] = COL;           ps[0] = 1;
      pc[1] = 2; pn[1] = nv;            ps[1] = 1;
      pc[2] = 0; pn[2] = ROW + COL - 1; ps[2] = 0;
      nph = 3;
    end else begin
      pc[0] = 7; pn[0] = 1;             ps[0] = 0;
      pc[1] = 6; pn[1] = nv;            ps[1] = 1;
      pc[2] = 5; pn[2] = ROW + 1;       ps[2] = 0;
      pc[3] = 4; pn[3] = ROW + COL - 1; ps[3] = 0;
      nph = 4;
    end
    ph = 0; rem = pn[0]; in_job = 1'b1; done_j = -1; dones = 0;

    start = 1'b1; mode = m; num_vec = LBW'(nv);
    @(negedge clk);
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL %s ready_before got %b want 1", name, ready); end
    @(posedge clk); #1;
    start = 1'b0;

    j = 0;
    while (done_j < 0 || j <= done_j + ROW + 1) begin
      if (j > 2000) begin
        errors++; $display("FAIL %s timeout got no completion want done", name);
        break;
      end
      emp = ($urandom_range(99) < stall_pct);
      l0_empty = emp;
      if (busy_starts && in_job && $urandom_range(3) == 0) begin
        start = 1'b1; mode = ~m; num_vec = LBW'($urandom_range(200));
      end else begin
        start = 1'b0;
      end
      while (in_job && ph < nph && rem == 0) begin
        ph++;
        if (ph < nph) rem = pn[ph];
      end
      exp_rd = 1'b0; exp_done = 1'b0; exp_ready = 1'b1; code = idle;
      if (in_job) begin
        exp_ready = 1'b0;
        if (ph == nph) begin
          exp_done = 1'b1; in_job = 1'b0; done_j = j;
        end else if (ps[ph] && emp) begin
          code = idle;
        end else begin
          code = pc[ph]; exp_rd = ps[ph]; rem--;
        end
      end
      hist[j] = code;
      @(negedge clk);
      if (done === 1'b1) dones++;
      vectors++; if (l0_rd !== exp_rd) begin errors++; $display("FAIL %s l0_rd cyc %0d got %b want %b", name, j, l0_rd, exp_rd); end
      vectors++; if (done !== exp_done) begin errors++; $display("FAIL %s done cyc %0d got %b want %b", name, j, done, exp_done); end
      vectors++; if (ready !== exp_ready || busy !== !exp_ready) begin
        errors++; $display("FAIL %s ready_busy cyc %0d got %b%b want %b%b", name, j, ready, busy, exp_ready, !exp_ready);
      end
      for (int r = 0; r < ROW; r++) begin
        if (j - 1 - r >= 0) begin
          vectors++;
          if (inst_row[3*r +: 3] !== 3'(hist[j-1-r])) begin
            errors++; $display("FAIL %s row%0d cyc %0d got %0d want %0d", name, r, j, inst_row[3*r +: 3], hist[j-1-r]);
          end
        end
      end
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0; l0_empty = 1'b0;
    vectors++; if (dones !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, dones); end
  endtask

  task automatic test_ws_basic();   run_job(1'b0, 4, 0, 1'b0, "ws_basic");  endtask
  task automatic test_ws_stall();   run_job(1'b0, 4, 30, 1'b0, "ws_stall"); endtask
  task automatic test_os();         run_job(1'b1, 5, 30, 1'b0, "os");       endtask
  task automatic test_zero_vec();
    run_job(1'b0, 0, 20, 1'b0, "ws_zero");
    run_job(1'b1, 0, 0, 1'b0, "os_zero");
  endtask
  task automatic test_busy_start(); run_job(1'b0, 6, 20, 1'b1, "busy_start"); endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++)
      run_job(1'($urandom_range(1)), int'($urandom_range(12)), int'($urandom_range(40)),
              1'($urandom_range(1)), "random");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; mode = 1'b0; num_vec = 8'd10; l0_empty = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (COL + 3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++; if (inst_row !== '0) begin errors++; $display("FAIL mid_reset inst_row got %h want 0", inst_row); end
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_reset ready got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset done got %b want 0", done); end
    vectors++; if (l0_rd !== 1'b0) begin errors++; $display("FAIL mid_reset l0_rd got %b want 0", l0_rd); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset after got done=%b ready=%b want done=0 ready=1", done, ready);
    end
    @(posedge clk); #1;
    run_job(1'b0, 3, 10, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ws_basic();
    test_ws_stall();
    test_os();
    test_zero_vec();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
